// File: rtl/dpram_be_clear.sv
// Dual-port block RAM with per-byte write enables, selectable read latency,
// optional write-to-read bypass and a clear sequencer that fills the array.
module dpram_be_clear #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int BYPASS        = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int LANES = DATA_WIDTH / BYTE_WIDTH,
    localparam int WORDS = 1 << ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_request,
    output logic                     busy,
    input  logic                     write_en,
    input  logic [LANES-1:0]         write_byte_en,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_en,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     read_valid
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = '1;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_count;
    logic [ADDRESS_WIDTH-1:0] w_next_count;
    logic                     w_clear_we;
    logic                     w_user_we;
    logic                     w_read_fire;
    logic [DATA_WIDTH-1:0]    w_read_word;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_valid;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Clear walks every address once, leaving IDLE on the edge that writes the last word.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (clear_request) begin
                    w_next_state = S_CLEAR;
                    w_next_count = '0;
                end
            end
            S_CLEAR: begin
                w_next_count = r_count + ADDRESS_WIDTH'(1);
                if (r_count == LAST_ADDRESS) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_CLEAR;
                w_next_count = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (r_state == S_CLEAR);
        w_clear_we  = (r_state == S_CLEAR);
        w_user_we   = write_en && (r_state == S_IDLE);
        w_read_fire = read_en && (r_state == S_IDLE);
    end

    // The array itself is never reset; only the sequencer gives it a known state.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_count] <= CLEAR_VALUE;
        end else if (w_user_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_byte_en[i]) begin
                    r_mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // A same-address write in the read cycle only shows through when bypass is built in.
    always_comb begin
        w_read_word = r_mem[read_address];
        if ((BYPASS != 0) && w_user_we && (write_address == read_address)) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_byte_en[i]) begin
                    w_read_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("dpram_be_clear: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    if (READ_LATENCY == 1) begin : g_latency1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_read_fire;
                if (w_read_fire) begin
                    r_data <= w_read_word;
                end
            end
        end
    end else if (READ_LATENCY == 2) begin : g_latency2
        logic [DATA_WIDTH-1:0] r_pipe_data;
        logic                  r_pipe_valid;

        // The output register only loads when the first stage carries a real read.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pipe_data  <= '0;
                r_pipe_valid <= 1'b0;
                r_data       <= '0;
                r_valid      <= 1'b0;
            end else begin
                r_pipe_valid <= w_read_fire;
                if (w_read_fire) begin
                    r_pipe_data <= w_read_word;
                end
                r_valid <= r_pipe_valid;
                if (r_pipe_valid) begin
                    r_data <= r_pipe_data;
                end
            end
        end
    end else begin : g_bad_latency
        $error("dpram_be_clear: READ_LATENCY must be 1 or 2");
    end

    assign read_data  = r_data;
    assign read_valid = r_valid;

endmodule

// File: doc/dpram_be_clear.md
# dpram_be_clear

Parametrised dual-port block RAM with one write port and one read port, a successor to the plain single-clock DPRAM. It adds per-byte write enables, a configurable read latency (1 or 2), an optional write-to-read collision bypass and a hardware clear sequencer that fills the array with a constant after reset or on request. Video and CPU-side blocks use it where tables must start in a known state: palettes, sprite attribute RAM and line buffers.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
- ADDRESS_WIDTH, 8, address bits; depth WORDS = 1 << ADDRESS_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; LANES = DATA_WIDTH / BYTE_WIDTH
- READ_LATENCY, 1, 1 or 2 cycles from read_en to read_data; other values are a synthesis error
- BYPASS, 0, 1 = same-cycle same-address read returns newly written bytes; 0 = returns old data
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sequencer
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- clear_request  input  1  pulse; starts a clear when the sequencer is idle
- busy  output  1  high while the clear sequencer owns the array
- write_en  input  1  write strobe
- write_byte_en  input  LANES  per-lane write mask; lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- write_address  input  ADDRESS_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- read_en  input  1  read strobe
- read_address  input  ADDRESS_WIDTH  read address
- read_data  output  DATA_WIDTH  registered read data, held between reads
- read_valid  output  1  one-cycle pulse marking new read_data

## Operation
- Sequencer states are IDLE and CLEAR, with a clear counter of ADDRESS_WIDTH bits.
- Reset (asynchronous) forces:
  - state = CLEAR, counter = 0, busy = 1;
  - read_data = 0, read_valid = 0;
  - all latency-2 pipeline registers = 0.
- The array contents are not reset; only the sequencer initialises them.
- In CLEAR, each edge writes CLEAR_VALUE to mem[counter] and increments counter.
- When the edge writes word WORDS-1, state goes to IDLE and busy goes to 0 on that same edge. The counter wraps to 0.
- In IDLE, clear_request = 1 at an edge moves state to CLEAR with counter = 0. User write and read in that same cycle are still performed. busy rises after that edge.
- clear_request while in CLEAR is ignored; there is no restart and no queueing.
- While busy = 1:
  - write_en is dropped entirely; the array is not touched by the user port.
  - read_en is ignored and read_valid stays 0; read_data holds its value.
- User write (IDLE, write_en = 1): only lanes with write_byte_en[i] = 1 are updated. write_byte_en = 0 is a no-op.
- User read (IDLE, read_en = 1): the word at read_address is captured.
- Collision (read_en, write_en, equal addresses, same cycle):
  - BYPASS = 0: returns the pre-write word.
  - BYPASS = 1: returns the pre-write word with enabled lanes replaced by write_data lanes.
- read_data updates only on a completed read. read_valid is 1 exactly in the cycle new data appears.

## Timing
- READ_LATENCY = 1: read_en sampled at edge N; read_data and read_valid are valid after edge N (one register stage).
- READ_LATENCY = 2: data is valid after edge N+1 (second register stage).
- Back-to-back reads give one result per cycle at either latency.
- Reads accepted in the cycle clear_request is taken still complete at their normal latency.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1. It is also visible at edge N when BYPASS = 1.
- Clear duration:
  - from reset release: busy stays high for exactly WORDS rising edges;
  - from clear_request at edge E: busy is high after E through edge E+WORDS, low after E+WORDS.
- Reset asserted mid-clear restarts from counter 0 with the full WORDS-edge duration after release.
- Reset asserted mid-read: pending pipeline stages are discarded, read_valid = 0.

## Test plan
- Post-reset clear, CLEAR_VALUE = 16'hA5A5, ADDRESS_WIDTH = 4 -> busy high 16 edges after release; reads of all 16 addresses return 16'hA5A5 with one read_valid pulse each.
- Byte-lane write: write 16'h1234 to addr 3 with be = 2'b11, then 16'hFF00 with be = 2'b10 -> read addr 3 returns 16'hFF34.
- Collision: word at addr 5 = 16'h0000; same cycle write 16'hBEEF be = 2'b01 and read addr 5 -> BYPASS = 0 returns 16'h0000, BYPASS = 1 returns 16'h00EF; a following read returns 16'h00EF in both builds.
- Latency: READ_LATENCY = 2, read_en for 3 consecutive cycles on addrs 0, 1, 2 -> read_valid high on cycles N+2..N+4 with the matching data; READ_LATENCY = 1 shifts this one cycle earlier.
- clear_request in IDLE with a write the same cycle to addr 7 = 16'h5555 -> write lands, then is overwritten by CLEAR_VALUE. A second clear_request mid-clear does not extend busy. Writes during busy are lost and reads during busy give no read_valid.
- Reset pulse at counter = 9 -> read_data = 0, busy stays 1, and the full 16-edge clear restarts after release.
